// File: rtl/multi_param_loader.sv
// multi_param_loader: round-robin sequencer copying per-channel
// parameter BRAMs into register buffers with registered read ports.
module multi_param_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int MAX_DEPTH  = 64,
  parameter int ADDR_W     = $clog2(MAX_DEPTH),
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1),
  parameter int BRAM_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            load_done_i,
  input  logic [NUM_CH*DEPTH_W-1:0]    depth_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] bram_dout_i,
  output logic [NUM_CH-1:0]            bram_en_o,
  output logic [ADDR_W-1:0]            bram_addr_o,
  output logic [NUM_CH-1:0]            ready_o,
  input  logic [NUM_CH*ADDR_W-1:0]     rd_addr_i,
  output logic [NUM_CH*DATA_WIDTH-1:0] rd_data_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DEPTH_W-1:0] MAX_LEN = DEPTH_W'(MAX_DEPTH);
  localparam logic [ADDR_W:0]    MAX_RD  = (ADDR_W + 1)'(MAX_DEPTH);

  logic [1:0]            state;
  logic [CH_W-1:0]       ch_sel;
  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       gnt_ch;
  logic [CH_W-1:0]       rr_nxt;
  logic                  gnt_ok;
  logic [NUM_CH-1:0]     gnt_mask;
  logic [NUM_CH-1:0]     prev_q;
  logic [NUM_CH-1:0]     rise_q;
  logic [NUM_CH-1:0]     pending;
  logic [NUM_CH-1:0]     ready;
  logic [NUM_CH-1:0]     ready_nxt;
  logic [DEPTH_W-1:0]    dlen;
  logic [DEPTH_W-1:0]    req_len;
  logic [DEPTH_W-1:0]    clamp_len;
  logic [ADDR_W-1:0]     idx;
  logic [BRAM_LAT-1:0]   pv;
  logic [ADDR_W-1:0]     pidx [BRAM_LAT];
  logic                  pipe_busy;
  logic [DATA_WIDTH-1:0] mem [NUM_CH][MAX_DEPTH];
  logic [NUM_CH*DATA_WIDTH-1:0] rd_q;

  // pick the first pending channel at or after the round-robin pointer
  always_comb begin
    gnt_ok = 1'b0;
    gnt_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (pending[(int'(rr_ptr) + k) % NUM_CH]) begin
        gnt_ok = 1'b1;
        gnt_ch = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  assign rr_nxt    = (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
  assign req_len   = depth_i[int'(gnt_ch)*DEPTH_W +: DEPTH_W];
  assign clamp_len = (req_len > MAX_LEN) ? MAX_LEN : req_len;
  assign gnt_mask  = (state == S_IDLE && gnt_ok) ?
                     (NUM_CH'(1) << gnt_ch) : '0;

  // stages before the last must be empty; the last one lands this edge
  always_comb begin
    pipe_busy = 1'b0;
    for (int s = 0; s < BRAM_LAT - 1; s++) pipe_busy = pipe_busy | pv[s];
  end

  // sequencer: grant, issue reads, drain captures, publish ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      ch_sel <= '0;
      dlen   <= '0;
      idx    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_ok) begin
            ch_sel <= gnt_ch;
            dlen   <= clamp_len;
            idx    <= '0;
            rr_ptr <= rr_nxt;
            state  <= (clamp_len == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          idx <= idx + 1'b1;
          if (DEPTH_W'(idx) == dlen - 1'b1) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!pipe_busy) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // a re-request during the load keeps the channel not ready
  always_comb begin
    ready_nxt = ready;
    if (state == S_DONE) ready_nxt[ch_sel] = ~pending[ch_sel];
    ready_nxt = ready_nxt & ~rise_q;
  end

  // request edge detect, pending set and ready bookkeeping
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q  <= '0;
      rise_q  <= '0;
      pending <= '0;
      ready   <= '0;
    end else begin
      prev_q  <= load_done_i;
      rise_q  <= load_done_i & ~prev_q;
      pending <= (pending & ~gnt_mask) | rise_q;
      ready   <= ready_nxt;
    end
  end

  // capture pipe tracking reads in flight through the BRAM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv <= '0;
      for (int s = 0; s < BRAM_LAT; s++) pidx[s] <= '0;
    end else begin
      pv[0]   <= (state == S_ISSUE);
      pidx[0] <= idx;
      for (int s = 1; s < BRAM_LAT; s++) begin
        pv[s]   <= pv[s-1];
        pidx[s] <= pidx[s-1];
      end
    end
  end

  // buffer write; contents survive reset
  always_ff @(posedge clk) begin
    if (rst_n && pv[BRAM_LAT-1])
      mem[ch_sel][pidx[BRAM_LAT-1]] <=
        bram_dout_i[int'(ch_sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  // per-channel registered read, zero outside the buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ({1'b0, rd_addr_i[c*ADDR_W +: ADDR_W]} < MAX_RD)
          rd_q[c*DATA_WIDTH +: DATA_WIDTH] <=
            mem[c][rd_addr_i[c*ADDR_W +: ADDR_W]];
        else
          rd_q[c*DATA_WIDTH +: DATA_WIDTH] <= '0;
      end
    end
  end

  assign bram_en_o   = (state == S_ISSUE) ? (NUM_CH'(1) << ch_sel) : '0;
  assign bram_addr_o = (state == S_ISSUE) ? idx : '0;
  assign ready_o     = ready;
  assign rd_data_o   = rd_q;

endmodule

// File: tb/tb_multi_param_loader.sv
// tb_multi_param_loader: directed and randomized loads checked
// against a buffer-level model and a behavioural latency-2 BRAM.
module tb_multi_param_loader;

  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int MD  = 48;
  localparam int AW  = $clog2(MD);
  localparam int DPW = $clog2(MD + 1);
  localparam int LAT = 2;

  logic                clk;
  logic                rst_n;
  logic [NCH-1:0]      load_done_i;
  logic [NCH*DPW-1:0]  depth_i;
  logic [NCH*DW-1:0]   bram_dout_i;
  logic [NCH-1:0]      bram_en_o;
  logic [AW-1:0]       bram_addr_o;
  logic [NCH-1:0]      ready_o;
  logic [NCH*AW-1:0]   rd_addr_i;
  logic [NCH*DW-1:0]   rd_data_o;

  multi_param_loader #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .MAX_DEPTH(MD), .BRAM_LAT(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_done_i(load_done_i),
    .depth_i(depth_i), .bram_dout_i(bram_dout_i),
    .bram_en_o(bram_en_o), .bram_addr_o(bram_addr_o),
    .ready_o(ready_o), .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] bmem [NCH][64];
  logic [DW-1:0] bq   [NCH][LAT];
  logic [DW-1:0] mbuf [NCH][MD];
  bit            known[NCH][MD];

  int vectors = 0;
  int miscompares = 0;
  int en_total = 0;
  int en_bad = 0;
  int rr_model = 0;
  int n, e0, d0, d1, ch, d, dc, ef;
  logic [NCH-1:0] en_h [16];
  logic [AW-1:0]  ad_h [16];
  logic           rd_h [16];

  // BRAM with fixed read latency; poison when not enabled
  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      bq[c][0] <= bram_en_o[c] ? bmem[c][bram_addr_o] : 16'hDEAD;
      for (int s = 1; s < LAT; s++) bq[c][s] <= bq[c][s-1];
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) bram_dout_i[c*DW +: DW] = bq[c][LAT-1];
  end

  // read counter and one-hot enable monitor
  always @(posedge clk) begin
    if (|bram_en_o) en_total <= en_total + 1;
    if (!$onehot0(bram_en_o)) en_bad <= en_bad + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_depth(int c, int v);
    depth_i[c*DPW +: DPW] = DPW'(v);
  endtask

  task automatic fill(int c);
    for (int a = 0; a < 64; a++) bmem[c][a] = DW'($urandom);
  endtask

  task automatic trigger(logic [NCH-1:0] m);
    load_done_i = load_done_i & ~m;
    tick();
    load_done_i = load_done_i | m;
  endtask

  task automatic wait_ready(int c, int budget, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!(cnt >= 2 && ready_o[c]) && cnt < budget);
    chk($sformatf("ready_timeout ch%0d", c), ready_o[c], 1'b1);
  endtask

  task automatic model_load(int c, int v);
    int dd;
    dd = (v > MD) ? MD : v;
    for (int a = 0; a < dd; a++) begin
      mbuf[c][a]  = bmem[c][a];
      known[c][a] = 1'b1;
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) begin
      for (int c = 0; c < NCH; c++) rd_addr_i[c*AW +: AW] = AW'(a);
      tick();
      for (int c = 0; c < NCH; c++) begin
        if (a >= MD)
          chk($sformatf("rd_oor ch%0d a%0d", c, a),
              rd_data_o[c*DW +: DW], 0);
        else if (known[c][a])
          chk($sformatf("rd ch%0d a%0d", c, a),
              rd_data_o[c*DW +: DW], mbuf[c][a]);
      end
    end
  endtask

  function automatic int exp_lat(int v);
    int dd;
    dd = (v > MD) ? MD : v;
    return (dd == 0) ? 3 : dd + LAT + 3;
  endfunction

  initial begin
    rst_n = 1'b0;
    load_done_i = '0;
    depth_i = '0;
    rd_addr_i = '0;
    repeat (3) tick();
    chk("rst ready", ready_o, 0);
    chk("rst en", bram_en_o, 0);
    chk("rst addr", bram_addr_o, 0);
    chk("rst rd", rd_data_o, 0);
    rst_n = 1'b1;
    tick();

    // basic load, exact cycle timing
    for (int a = 0; a < 64; a++) bmem[0][a] = DW'(3 * a);
    set_depth(0, 8);
    e0 = en_total;
    trigger(2'b01);
    for (int j = 0; j < 15; j++) begin
      tick();
      en_h[j] = bram_en_o;
      ad_h[j] = bram_addr_o;
      rd_h[j] = ready_o[0];
    end
    chk("t1 en T+1", en_h[1], 2'b00);
    chk("t1 en T+2", en_h[2], 2'b01);
    chk("t1 addr T+2", ad_h[2], 0);
    chk("t1 addr T+5", ad_h[5], 3);
    chk("t1 en T+9", en_h[9], 2'b01);
    chk("t1 addr T+9", ad_h[9], 7);
    chk("t1 en T+10", en_h[10], 2'b00);
    chk("t1 ready T+12", rd_h[12], 1'b0);
    chk("t1 ready T+13", rd_h[13], 1'b1);
    chk("t1 nreads", en_total - e0, 8);
    model_load(0, 8);
    rr_model = 1;
    read_all();

    // simultaneous requests follow the round-robin pointer
    for (int rep = 0; rep < 2; rep++) begin
      fill(0);
      fill(1);
      d0 = $urandom_range(1, 10);
      d1 = $urandom_range(1, 10);
      set_depth(0, d0);
      set_depth(1, d1);
      ef = rr_model;
      trigger(2'b11);
      n = 0;
      do begin tick(); n++; end while (bram_en_o == 0 && n < 30);
      chk($sformatf("t2 first grant rep%0d", rep), bram_en_o,
          NCH'(1) << ef);
      wait_ready(1 - ef, 200, n);
      chk("t2 both ready", ready_o, 2'b11);
      model_load(0, d0);
      model_load(1, d1);
      read_all();
      if (rep == 0) begin
        fill(1);
        set_depth(1, 5);
        trigger(2'b10);
        wait_ready(1, 200, n);
        model_load(1, 5);
        rr_model = 0;
      end
    end

    // re-request of the loading channel forces a reload
    fill(1);
    set_depth(1, 12);
    trigger(2'b10);
    repeat (4) tick();
    load_done_i[1] = 1'b0;
    tick();
    fill(1);
    load_done_i[1] = 1'b1;
    tick();
    repeat (12) tick();
    chk("t3 ready held low", ready_o[1], 1'b0);
    wait_ready(1, 300, n);
    model_load(1, 12);
    rr_model = 0;
    read_all();

    // zero-length load
    set_depth(0, 0);
    e0 = en_total;
    trigger(2'b01);
    wait_ready(0, 100, n);
    chk("t4 d0 latency", n - 1, 3);
    chk("t4 d0 nreads", en_total - e0, 0);

    // oversize length clamps to the buffer size
    fill(1);
    set_depth(1, 63);
    e0 = en_total;
    trigger(2'b10);
    wait_ready(1, 200, n);
    chk("t4 clamp latency", n - 1, exp_lat(63));
    chk("t4 clamp nreads", en_total - e0, MD);
    model_load(1, 63);
    read_all();

    // reset in the middle of a load
    load_done_i[1] = 1'b0;
    fill(0);
    set_depth(0, 20);
    trigger(2'b01);
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    chk("t5 rst en", bram_en_o, 0);
    chk("t5 rst addr", bram_addr_o, 0);
    chk("t5 rst ready", ready_o, 0);
    chk("t5 rst rd", rd_data_o, 0);
    tick();
    fill(0);
    rst_n = 1'b1;
    rr_model = 0;
    e0 = en_total;
    wait_ready(0, 300, n);
    chk("t5 reload latency", n - 1, exp_lat(20));
    chk("t5 reload nreads", en_total - e0, 20);
    model_load(0, 20);
    read_all();

    // randomized single-channel loads
    for (int it = 0; it < 12; it++) begin
      ch = $urandom_range(0, NCH - 1);
      d = $urandom_range(0, 63);
      dc = (d > MD) ? MD : d;
      fill(ch);
      set_depth(ch, d);
      e0 = en_total;
      trigger(NCH'(1) << ch);
      wait_ready(ch, 200, n);
      chk($sformatf("rnd%0d latency", it), n - 1, exp_lat(d));
      chk($sformatf("rnd%0d nreads", it), en_total - e0, dc);
      model_load(ch, d);
      read_all();
    end

    chk("en onehot", en_bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
